// File: rtl/mic_pkg.sv
// Shared types and sizing helpers for the multi-microphone PDM beamformer.
// Holds the FSM state type, width helpers and the PDM-to-bipolar mapping.
`timescale 1ns/1ps
package mic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DUMP
    } bf_state_t;

    localparam int BIPOLAR_ONE  = 1;
    localparam int BIPOLAR_ZERO = -1;

    function automatic int delay_width(input int max_delay);
        return (max_delay > 1) ? $clog2(max_delay) : 1;
    endfunction

    // Room for WINDOW_SIZE frames of s*s, each below (N_MICS+1)^2.
    function automatic int acc_width(input int n_mics, input int window_size);
        return 2 * $clog2(n_mics + 1) + $clog2(window_size);
    endfunction

    function automatic int bipolar(input logic pdm_bit);
        return pdm_bit ? BIPOLAR_ONE : BIPOLAR_ZERO;
    endfunction

endpackage

// File: rtl/pdm_delay_line.sv
// Per-microphone history of PDM bits with a selectable tap (MAX_DELAY >= 2).
// Tap 0 is the incoming bit, tap d is the bit shifted in d frames earlier.
`timescale 1ns/1ps
module pdm_delay_line #(
    parameter int MAX_DELAY = 16,
    parameter int DW        = 4
) (
    input  logic          s_clk,
    input  logic          rst,
    input  logic          shift_en,
    input  logic          din,
    input  logic [DW-1:0] sel,
    output logic          tap
);

    logic [MAX_DELAY-2:0] past;
    logic [MAX_DELAY-1:0] hist;

    assign hist = {past, din};
    assign tap  = hist[sel];

    // NOTE: the history is reset like any control register; a stale history
    // would otherwise leak the previous window into the first frames after reset.
    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            past <= '0;
        end else if (shift_en) begin
            past <= hist[MAX_DELAY-2:0];
        end
    end

endmodule

// File: rtl/multi_mic_beamforming.sv
// Delay-and-sum beamformer over stereo PDM lines, integrating s*s per window.
// Optional MULTI_MIC_BEAMFORMING_PEAK_EN adds a peak_power output.
`timescale 1ns/1ps
module multi_mic_beamforming
    import mic_pkg::*;
#(
    parameter int  N_MICS      = 4,
    parameter int  WINDOW_SIZE = 256,
    parameter int  MAX_DELAY   = 16,
    localparam int DW          = delay_width(MAX_DELAY),
    localparam int ACC_W       = acc_width(N_MICS, WINDOW_SIZE)
) (
    input  logic                   s_clk,
    input  logic                   rst,
    input  logic                   mic_clk,
    input  logic [N_MICS/2-1:0]    mic_data,
    input  logic [N_MICS*DW-1:0]   cfg_delay,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [ACC_W-1:0]       power,
    output logic                   power_valid
`ifdef MULTI_MIC_BEAMFORMING_PEAK_EN
    ,
    output logic [ACC_W-1:0]       peak_power
`endif
);

    localparam int HALF  = N_MICS / 2;
    localparam int CNT_W = $clog2(WINDOW_SIZE);
    localparam int SQ_W  = 2 * $clog2(N_MICS + 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(WINDOW_SIZE - 1);

    bf_state_t           state_q, state_d;
    logic                clk_meta, clk_sync, clk_prev;
    logic [HALF-1:0]     data_meta, data_sync, even_bits;
    logic                mic_rise, mic_fall, frame_stb;
    logic [N_MICS-1:0]   frame_bits, taps;
    logic [N_MICS*DW-1:0] active_delay, pending_delay;
    logic [CNT_W-1:0]    frame_cnt;
    logic [ACC_W-1:0]    acc;
    logic [SQ_W-1:0]     frame_sq;
    int                  frame_sum;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 1'b0;
            clk_sync  <= 1'b0;
            clk_prev  <= 1'b0;
            data_meta <= '0;
            data_sync <= '0;
            even_bits <= '0;
        end else begin
            clk_meta  <= mic_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= mic_data;
            data_sync <= data_meta;
            if (mic_rise) begin
                even_bits <= data_sync;
            end
        end
    end

    assign mic_rise  = clk_sync & ~clk_prev;
    assign mic_fall  = ~clk_sync & clk_prev;
    assign frame_stb = mic_fall && (state_q != ST_IDLE);

    // Odd mics arrive with the completing falling edge, even mics were held.
    for (genvar k = 0; k < HALF; k++) begin : g_frame
        assign frame_bits[2*k]   = even_bits[k];
        assign frame_bits[2*k+1] = data_sync[k];
    end

    for (genvar i = 0; i < N_MICS; i++) begin : g_line
        pdm_delay_line #(
            .MAX_DELAY (MAX_DELAY),
            .DW        (DW)
        ) u_line (
            .s_clk    (s_clk),
            .rst      (rst),
            .shift_en (frame_stb),
            .din      (frame_bits[i]),
            .sel      (active_delay[i*DW +: DW]),
            .tap      (taps[i])
        );
    end

    always_comb begin
        frame_sum = 0;
        for (int i = 0; i < N_MICS; i++) begin
            frame_sum = frame_sum + bipolar(taps[i]);
        end
        frame_sq = SQ_W'(frame_sum * frame_sum);
    end

    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (mic_rise) state_d = ST_ACCUM;
            ST_ACCUM: if (frame_stb && frame_cnt == LAST_FRAME) state_d = ST_DUMP;
            ST_DUMP:  state_d = ST_ACCUM;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            frame_cnt   <= '0;
            power       <= '0;
            power_valid <= 1'b0;
        end else begin
            power_valid <= 1'b0;
            case (state_q)
                ST_ACCUM: begin
                    if (frame_stb) begin
                        acc       <= acc + ACC_W'(frame_sq);
                        frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + CNT_W'(1);
                    end
                end
                ST_DUMP: begin
                    power       <= acc;
                    power_valid <= 1'b1;
                    // A frame landing on the dump cycle opens the new window.
                    if (frame_stb) begin
                        acc       <= ACC_W'(frame_sq);
                        frame_cnt <= CNT_W'(1);
                    end else begin
                        acc       <= '0;
                        frame_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Steering delays only switch at a window boundary.
    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            cfg_ready     <= 1'b1;
            pending_delay <= '0;
            active_delay  <= '0;
        end else if (state_q == ST_DUMP && !cfg_ready) begin
            active_delay <= pending_delay;
            cfg_ready    <= 1'b1;
        end else if (cfg_valid && cfg_ready) begin
            pending_delay <= cfg_delay;
            cfg_ready     <= 1'b0;
        end
    end

`ifdef MULTI_MIC_BEAMFORMING_PEAK_EN
    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            peak_power <= '0;
        end else if (state_q == ST_DUMP && acc > peak_power) begin
            peak_power <= acc;
        end
    end
`else
    // Without peak tracking the window power is the only result.
`endif

endmodule
